// File: rtl/wb_master_bridge_pkg.sv
// ============================================================================
// Module   : wb_master_bridge_pkg
// Brief    : State encoding and harness register map shared by the bridge and
//            any bench or initiator that talks to the harness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_master_bridge_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUS  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [31:0] ADR_ACTIVE = 32'h3000_0000;
  localparam logic [31:0] ADR_WS2812 = 32'h3000_0100;
  localparam logic [31:0] ADR_7SEG   = 32'h3000_0200;

endpackage : wb_master_bridge_pkg

`default_nettype wire

// File: rtl/wb_master_bridge.sv
// ============================================================================
// Module   : wb_master_bridge
// Brief    : Single-outstanding Wishbone classic initiator bridging a command
//            stream to one bus cycle and a response stream, with bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        cyc_nxt, stb_nxt, we_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] adr_nxt, dat_o_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic [31:0] rsp_dat_nxt;
  logic        timed_out;

  assign cmd_ready = (state == ST_IDLE) && !wb_rst_i;
  assign timed_out = (cnt == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid && cmd_ready)  state_nxt = ST_BUS;
      ST_BUS:  if (wbm_ack_i || timed_out)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)               state_nxt = ST_IDLE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_nxt       = wbm_cyc_o;
    stb_nxt       = wbm_stb_o;
    we_nxt        = wbm_we_o;
    sel_nxt       = wbm_sel_o;
    adr_nxt       = wbm_adr_o;
    dat_o_nxt     = wbm_dat_o;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_dat_nxt   = rsp_dat;
    cnt_nxt       = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = cmd_we;
          sel_nxt   = cmd_sel;
          adr_nxt   = cmd_adr;
          dat_o_nxt = cmd_dat;
          cnt_nxt   = 8'd0;
        end
      end
      ST_BUS: begin
        cnt_nxt = cnt + 8'd1;
        // An ack arriving on the final counted cycle still completes normally.
        if (wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_dat_nxt   = wbm_we_o ? 32'd0 : wbm_dat_i;
        end else if (timed_out) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_dat_nxt   = wbm_we_o ? 32'd0 : ERR_DATA;
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= 32'd0;
      cnt       <= 8'd0;
    end else begin
      wbm_cyc_o <= cyc_nxt;
      wbm_stb_o <= stb_nxt;
      wbm_we_o  <= we_nxt;
      wbm_sel_o <= sel_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_o_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_dat   <= rsp_dat_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule : wb_master_bridge

`default_nettype wire
